conversor_serie_para_paralelo: RTL and testbench

Receive end of the 6-bit parallel-to-serial link: rebuilds parallel words from an MSB-first serial bit stream. Bits are qualified by a per-bit valid strobe, and each word is framed by a start marker on its MSB. Each completed word goes into an output holding register with a valid/ready handshake, so the next word can be received while the current one waits to be consumed. Sits directly after the serializer or its wire/channel, feeding parallel consumers.

---
 rtl/conversor_serie_para_paralelo_pkg.sv | 8 +
 rtl/conversor_serie_para_paralelo_if.sv | 20 ++
 rtl/conversor_serie_para_paralelo_registrador.sv | 17 +
 rtl/conversor_serie_para_paralelo.sv | 73 +++++++
 tb/tb_conversor_serie_para_paralelo.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/conversor_serie_para_paralelo_pkg.sv
// conversor_pkg: shared word width, receiver FSM encoding and counter sizing for the serial link.
package conversor_pkg;
   localparam int WORD_W = 6;
   typedef enum logic {IDLE, SHIFT} estado_t;
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction
endpackage

// File: rtl/conversor_serie_para_paralelo_if.sv
// conversor_serie_para_paralelo_if: serial input side plus parallel valid/ready output side of the receiver.
interface conversor_serie_para_paralelo_if import conversor_pkg::*; #(parameter int WIDTH = WORD_W) ();
   logic             serial_in;
   logic             serial_valid;
   logic             frame_start;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             data_ready;
   logic             overrun;
   logic             overrun_clr;
   logic             frame_err;
   modport master (
      output serial_in, serial_valid, frame_start, data_ready, overrun_clr,
      input  data_out, data_valid, overrun, frame_err
   );
   modport slave (
      input  serial_in, serial_valid, frame_start, data_ready, overrun_clr,
      output data_out, data_valid, overrun, frame_err
   );
endinterface

// File: rtl/conversor_serie_para_paralelo_registrador.sv
// registrador_deslocamento_entrada: left-shift register; par_d is the next value so a word can be
// captured on the same edge that shifts in its last bit.
module registrador_deslocamento_entrada import conversor_pkg::*; #(parameter int WIDTH = WORD_W) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             load_first,
   input  logic             bit_in,
   output logic [WIDTH-1:0] par_d
);
   logic [WIDTH-1:0] q_q, q_d;
   always_comb q_d = load_first ? WIDTH'(bit_in) : en ? {q_q[WIDTH-2:0], bit_in} : q_q;
   assign par_d = q_d;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) q_q <= '0;
      else q_q <= q_d;
endmodule

// File: rtl/conversor_serie_para_paralelo.sv
// conversor_serie_para_paralelo: rebuilds MSB-first framed serial words into a valid/ready holding register.
module conversor_serie_para_paralelo import conversor_pkg::*; #(parameter int WIDTH = WORD_W) (
   input logic clk,
   input logic reset_n,
   conversor_serie_para_paralelo_if.slave bus
);
   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   estado_t          estado_q, estado_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d, palavra;
   logic             valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
   logic             inicio, desloca, completa;
   // frame_start always wins, so a marker on the last bit position resyncs instead of completing
   always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q;
      ferr_d   = 1'b0;
      inicio   = 1'b0;
      desloca  = 1'b0;
      completa = 1'b0;
      if (bus.serial_valid && bus.frame_start) begin
         inicio   = 1'b1;
         cnt_d    = CW'(1);
         estado_d = SHIFT;
         ferr_d   = estado_q == SHIFT;
      end else if (bus.serial_valid && estado_q == SHIFT) begin
         desloca  = 1'b1;
         completa = cnt_q == LAST;
         cnt_d    = completa ? '0 : cnt_q + CW'(1);
         estado_d = completa ? IDLE : SHIFT;
      end
   end
   registrador_deslocamento_entrada #(.WIDTH(WIDTH)) u_reg (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (desloca),
      .load_first (inicio),
      .bit_in     (bus.serial_in),
      .par_d      (palavra)
   );
   // a freshly completed word may replace the held one only if the held one leaves on this edge
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = bus.overrun_clr ? 1'b0 : ovr_q;
      if (completa && valid_q && !bus.data_ready) ovr_d = 1'b1;
      else if (completa) begin
         data_d  = palavra;
         valid_d = 1'b1;
      end else if (bus.data_ready) valid_d = 1'b0;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         estado_q <= IDLE;
         cnt_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
         ferr_q   <= ferr_d;
      end
   assign bus.data_out   = data_q;
   assign bus.data_valid = valid_q;
   assign bus.overrun    = ovr_q;
   assign bus.frame_err  = ferr_q;
endmodule

// File: tb/tb_conversor_serie_para_paralelo.sv
// tb_conversor_serie_para_paralelo: directed vectors with hand-computed expectations for the receiver.
module tb_conversor_serie_para_paralelo;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk = 0;
   int   n_ok = 0;
   conversor_serie_para_paralelo_if #(.WIDTH(6)) bus ();
   conversor_serie_para_paralelo #(.WIDTH(6)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_ok++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic send_bit(input logic b, input logic fs);
      bus.serial_valid = 1'b1;
      bus.serial_in    = b;
      bus.frame_start  = fs;
      @(posedge clk);
      #1;
      bus.serial_valid = 1'b0;
      bus.frame_start  = 1'b0;
   endtask
   task automatic idle_cycle();
      bus.serial_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask
   task automatic send_word(input logic [5:0] w);
      for (int i = 5; i >= 0; i--) send_bit(w[i], i == 5);
   endtask
   initial begin
      bus.serial_in = 1'b0;
      bus.serial_valid = 1'b0;
      bus.frame_start = 1'b0;
      bus.data_ready = 1'b1;
      bus.overrun_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", bus.data_valid, 0);
      check("rst_data", bus.data_out, 0);
      check("rst_ovr", bus.overrun, 0);
      check("rst_ferr", bus.frame_err, 0);
      @(negedge clk);
      reset_n = 1'b1;
      // single word
      send_word(6'b101010);
      check("w1_valid", bus.data_valid, 1);
      check("w1_data", bus.data_out, 6'b101010);
      check("w1_ovr", bus.overrun, 0);
      check("w1_ferr", bus.frame_err, 0);
      idle_cycle();
      check("w1_consumed", bus.data_valid, 0);
      // back-to-back with a 3-cycle gap inside the second word
      send_word(6'b101010);
      check("b2b_a", bus.data_out, 6'b101010);
      send_bit(1, 1);
      check("b2b_taken", bus.data_valid, 0);
      send_bit(1, 0);
      send_bit(0, 0);
      repeat (3) idle_cycle();
      check("gap_nodata", bus.data_valid, 0);
      send_bit(0, 0);
      send_bit(1, 0);
      check("gap_nodata2", bus.data_valid, 0);
      send_bit(1, 0);
      check("b2b_b_valid", bus.data_valid, 1);
      check("b2b_b_data", bus.data_out, 6'b110011);
      idle_cycle();
      // overrun
      bus.data_ready = 1'b0;
      send_word(6'b110011);
      check("ov_first", bus.data_out, 6'b110011);
      send_word(6'b000111);
      check("ov_hold", bus.data_out, 6'b110011);
      check("ov_set", bus.overrun, 1);
      check("ov_valid", bus.data_valid, 1);
      idle_cycle();
      check("ov_sticky", bus.overrun, 1);
      bus.overrun_clr = 1'b1;
      idle_cycle();
      bus.overrun_clr = 1'b0;
      check("ov_clr", bus.overrun, 0);
      bus.data_ready = 1'b1;
      idle_cycle();
      check("ov_drain", bus.data_valid, 0);
      // early frame_start resync
      send_bit(1, 1);
      send_bit(0, 0);
      send_bit(1, 0);
      send_bit(0, 1);
      check("rs_ferr", bus.frame_err, 1);
      check("rs_nodata", bus.data_valid, 0);
      send_bit(1, 0);
      check("rs_pulse", bus.frame_err, 0);
      send_bit(1, 0);
      send_bit(1, 0);
      send_bit(1, 0);
      send_bit(0, 0);
      check("rs_data", bus.data_out, 6'b011110);
      check("rs_valid", bus.data_valid, 1);
      idle_cycle();
      // async reset mid-word while a word is held
      bus.data_ready = 1'b0;
      send_word(6'b001100);
      send_bit(1, 1);
      send_bit(1, 0);
      send_bit(1, 0);
      send_bit(0, 0);
      check("pre_rst_valid", bus.data_valid, 1);
      #2 reset_n = 1'b0;
      #1;
      check("arst_valid", bus.data_valid, 0);
      check("arst_data", bus.data_out, 0);
      @(negedge clk);
      reset_n = 1'b1;
      bus.data_ready = 1'b1;
      send_word(6'b010101);
      check("post_rst_data", bus.data_out, 6'b010101);
      check("post_rst_valid", bus.data_valid, 1);
      // transfer and completion on the same edge
      bus.data_ready = 1'b0;
      for (int i = 5; i >= 1; i--) send_bit(i == 5 || i == 0, i == 5);
      check("same_hold", bus.data_out, 6'b010101);
      bus.data_ready = 1'b1;
      send_bit(1, 0);
      check("same_data", bus.data_out, 6'b100001);
      check("same_valid", bus.data_valid, 1);
      check("same_ovr", bus.overrun, 0);
      idle_cycle();
      // frame_start on the last bit position
      send_bit(1, 1);
      repeat (4) send_bit(0, 0);
      send_bit(1, 1);
      check("last_ferr", bus.frame_err, 1);
      check("last_nodata", bus.data_valid, 0);
      repeat (4) send_bit(1, 0);
      send_bit(0, 0);
      check("last_data", bus.data_out, 6'b111110);
      check("last_valid", bus.data_valid, 1);
      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end
endmodule
